// File: rtl/axis_frame_sink_pkg.sv
// rtl/axis_frame_sink_pkg.sv - shared states, frame depth and pointer sizing for the frame sink
package axis_frame_sink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    HOLD    = 2'b10
  } state_t;

  // Frame length produced by the upstream stream generator.
  localparam int NUMBER_OF_OUTPUT_WORDS = 8;

  function automatic int ptr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_frame_buf.sv
// rtl/axis_frame_buf.sv - single-write/single-read register buffer with a registered read port
module axis_frame_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              wr_en_i,
  input  logic [IW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [IW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is left unreset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_sink.sv
// rtl/axis_frame_sink.sv - captures and checks one generator frame, holds it until drained
module axis_frame_sink
  import axis_frame_sink_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH  = 32,
  parameter int NUMBER_OF_INPUT_WORDS = NUMBER_OF_OUTPUT_WORDS,
  parameter int CNT_WIDTH             = 16
) (
  input  logic                                   S_AXIS_ACLK,
  input  logic                                   S_AXIS_ARESETN,
  output logic                                   S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]        S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]      S_AXIS_TSTRB,
  input  logic                                   S_AXIS_TLAST,
  input  logic                                   S_AXIS_TVALID,
  output logic                                   frame_ready,
  output logic [ptr_width(NUMBER_OF_INPUT_WORDS)-1:0] frame_len,
  input  logic                                   buf_rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]        buf_rd_data,
  output logic                                   buf_rd_valid,
  output logic [CNT_WIDTH-1:0]                   frame_count,
  output logic [CNT_WIDTH-1:0]                   err_count,
  output logic                                   err_sticky
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int PW = ptr_width(NUMBER_OF_INPUT_WORDS);
  localparam int IW = $clog2(NUMBER_OF_INPUT_WORDS);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUMBER_OF_INPUT_WORDS - 1);

  state_t               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        frame_len_q, frame_len_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 err_sticky_q, err_sticky_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rd_valid_q;

  logic accept, pop, last_slot, close, data_err, len_err, beat_err;

  assign accept    = S_AXIS_TVALID && (state_q == RECEIVE);
  assign pop       = buf_rd_en && (state_q == HOLD);
  assign last_slot = (wr_ptr_q == LAST_PTR);
  assign close     = accept && (S_AXIS_TLAST || last_slot);
  assign data_err  = (S_AXIS_TDATA != (DW'(wr_ptr_q) + DW'(1))) || !(&S_AXIS_TSTRB);
  assign len_err   = (S_AXIS_TLAST && !last_slot) || (!S_AXIS_TLAST && last_slot);
  assign beat_err  = data_err || len_err;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_len_d  = frame_len_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    frame_err_d  = frame_err_q;
    case (state_q)
      IDLE: state_d = RECEIVE;
      RECEIVE: begin
        if (close) begin
          state_d     = HOLD;
          wr_ptr_d    = '0;
          frame_len_d = wr_ptr_q + PW'(1);
          frame_err_d = 1'b0;
          if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          // The closing beat's own error still counts toward this frame.
          if (frame_err_q || beat_err) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
          end
        end else if (accept) begin
          wr_ptr_d    = wr_ptr_q + PW'(1);
          frame_err_d = frame_err_q || beat_err;
        end
      end
      HOLD: begin
        if (pop) begin
          if (rd_ptr_q == frame_len_q - PW'(1)) begin
            rd_ptr_d = '0;
            state_d  = RECEIVE;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_len_q  <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_len_q  <= frame_len_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      frame_err_q  <= frame_err_d;
      rd_valid_q   <= pop;
    end
  end

  axis_frame_buf #(
    .DATA_W (DW),
    .DEPTH  (NUMBER_OF_INPUT_WORDS),
    .IW     (IW)
  ) u_buf (
    .clk_i     (S_AXIS_ACLK),
    .resetn_i  (S_AXIS_ARESETN),
    .wr_en_i   (accept),
    .wr_addr_i (wr_ptr_q[IW-1:0]),
    .wr_data_i (S_AXIS_TDATA),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q[IW-1:0]),
    .rd_data_o (buf_rd_data)
  );

  assign S_AXIS_TREADY = (state_q == RECEIVE);
  assign frame_ready   = (state_q == HOLD);
  assign frame_len     = frame_len_q;
  assign buf_rd_valid  = rd_valid_q;
  assign frame_count   = frame_cnt_q;
  assign err_count     = err_cnt_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: doc/axis_frame_sink.md
Name: axis_frame_sink

Overview:
AXI4-Stream slave that sits directly downstream of the team's 8-word stream generator. It captures one frame of up to NUMBER_OF_INPUT_WORDS beats into a local buffer, checks the payload against the generator's pattern (1, 2, …, N), checks TLAST placement and TSTRB, and keeps frame and error counters. It then holds the frame until a local consumer drains it through a simple read port, and only after that accepts the next frame.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream data width in bits (multiple of 8).
NUMBER_OF_INPUT_WORDS, 8, maximum beats per frame and buffer depth (≥2).
CNT_WIDTH, 16, width of the frame and error counters.

Ports:
S_AXIS_ACLK  in  1  clock. One clock only; all logic is on its rising edge.
S_AXIS_ARESETN  in  1  reset. Synchronous, active-low.
S_AXIS_TREADY  out  1  slave ready.
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data.
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
S_AXIS_TLAST  in  1  end of frame.
S_AXIS_TVALID  in  1  master valid.
frame_ready  out  1  a complete frame is held in the buffer.
frame_len  out  clog2(NUMBER_OF_INPUT_WORDS+1)  beats in the held frame (1..N).
buf_rd_en  in  1  pop one word from the held frame.
buf_rd_data  out  C_S_AXIS_TDATA_WIDTH  popped word.
buf_rd_valid  out  1  buf_rd_data is valid this cycle.
frame_count  out  CNT_WIDTH  frames received; saturating.
err_count  out  CNT_WIDTH  frames with at least one error; saturating.
err_sticky  out  1  set on any error, cleared only by reset.

Behaviour:
- Reset, while S_AXIS_ARESETN is low at a clock edge:
  - state = IDLE; all pointers = 0.
  - All outputs = 0: TREADY, frame_ready, frame_len, buf_rd_data, buf_rd_valid, frame_count, err_count, err_sticky.
  - Reset in mid-frame or mid-drain discards the frame. Buffer contents need not be cleared.
- States and transitions:
  - IDLE: exactly one cycle, then RECEIVE.
  - RECEIVE: TREADY = 1. Goes to HOLD when the frame closes (see below).
  - HOLD: TREADY = 0. Goes back to RECEIVE after the last word is popped.
- TREADY is decoded from the registered state, not from any input combinationally.
- Beat acceptance:
  - A beat is accepted when TVALID && TREADY.
  - TDATA is written at wr_ptr, then wr_ptr increments.
- Frame close: on the accepted beat that has TLAST = 1, or that lands at wr_ptr = N-1, whichever comes first.
  - On the close cycle: frame_len <= wr_ptr+1, wr_ptr <= 0, frame_count increments (saturating at all-ones).
  - Next cycle: state = HOLD, TREADY = 0.
- Checks, evaluated per accepted beat:
  - Data error: TDATA != wr_ptr+1, or TSTRB not all-ones.
  - Length error: TLAST = 1 with wr_ptr < N-1 (early), or TLAST = 0 at wr_ptr = N-1 (missing; the frame is still closed).
  - Errors accumulate into a per-frame flag. At frame close, if the flag is set (including an error on the closing beat), err_count increments (saturating) and err_sticky is set. The flag then clears.
- Drain, in HOLD:
  - frame_ready = 1.
  - buf_rd_en at cycle k: buf_rd_data = buf[rd_ptr] and buf_rd_valid = 1 at cycle k+1. rd_ptr increments.
  - buf_rd_valid is a one-cycle pulse per pop.
  - When the pop hits rd_ptr = frame_len-1: rd_ptr <= 0, frame_ready drops, state = RECEIVE. TREADY = 1 at k+1.
  - buf_rd_en outside HOLD is ignored: no pulse, no pointer change.
- Upstream stalls (TVALID low) in RECEIVE: no state or pointer change.
- Back-to-back beats are accepted at one per cycle.

Decomposition:
- Shared package:
  - State encodings IDLE = 2'b00, RECEIVE = 2'b01, HOLD = 2'b10.
  - NUMBER_OF_OUTPUT_WORDS/NUMBER_OF_INPUT_WORDS default constant, shared with the upstream generator.
  - A pointer-width function based on clog2(N+1).
- One sub-module, axis_frame_buf: an N-deep single-write/single-read register buffer with a registered read port. Control, checks and counters stay in the top level.

Test Plan:
1. Nominal frame: upstream-pattern frame 1..8, TLAST on beat 8, TVALID held high, then 8 consecutive buf_rd_en. Required: TREADY drops the cycle after beat 8; frame_ready = 1, frame_len = 8; pops return 1..8 on consecutive cycles; frame_count = 1, err_count = 0; TREADY = 1 the cycle after the 8th pop.
2. Early TLAST: 3 beats (1, 2, 3) with TLAST on beat 3. Required: frame_len = 3, err_count = 1, err_sticky = 1; exactly 3 pops return the buffer to RECEIVE.
3. Missing TLAST plus bad data: 8 beats with beat 5 = 0xDEAD and no TLAST. Required: frame closes after beat 8 with frame_len = 8, err_count increments once (not twice), popped word 5 = 0xDEAD.
4. Stalls: TVALID toggled every other cycle during a frame and buf_rd_en pulsed while in RECEIVE. Required: all 8 words captured in order; no buf_rd_valid pulses outside HOLD.
5. Reset mid-operation: reset asserted after 4 beats, and separately after 2 pops. Required: next cycle all outputs are 0 and state is IDLE; the following full frame captures 1..8 correctly with frame_count = 1.
6. Saturation: with CNT_WIDTH = 2, send 5 good frames. Required: frame_count holds at 3.
